// File: rtl/audio_boxcar_decimator_if.sv
// Stream interface for the boxcar decimator: clock-rate sample input,
// valid/ready averaged output, FIFO status and overflow control.
interface audio_boxcar_decimator_if #(
  parameter int WIDTH           = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic                       in_valid;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [FIFO_DEPTH_LOG2:0]   fifo_level;
  logic                       overflow;
  logic                       clear_ovf;

  // Producer / consumer side (testbench or surrounding audio path)
  modport master (
    output in_valid, in_data, out_ready, clear_ovf,
    input  out_valid, out_data, fifo_level, overflow
  );

  // Decimator side
  modport slave (
    input  in_valid, in_data, out_ready, clear_ovf,
    output out_valid, out_data, fifo_level, overflow
  );
endinterface

// File: rtl/audio_boxcar_decimator.sv
// Boxcar decimator: averages each block of 2^DECIM_LOG2 valid input samples
// and queues the averages in a show-ahead FIFO with valid/ready output.
// A finished average arriving at a full FIFO (without a same-edge pop) is
// dropped and flagged in the sticky overflow bit.
module audio_boxcar_decimator #(
  parameter int WIDTH           = 16,
  parameter int DECIM_LOG2      = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  audio_boxcar_decimator_if.slave bus
);

  localparam int ACC_W = WIDTH + DECIM_LOG2;
  localparam int CNT_W = DECIM_LOG2;
  localparam int PTR_W = FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [CNT_W-1:0] CNT_LAST  = {CNT_W{1'b1}};
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);

  // State
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q, overflow_d;

  // Datapath / control intermediates
  logic signed [ACC_W-1:0] in_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [WIDTH-1:0]        avg_s;
  logic                    block_end_s;
  logic                    pop_s;
  logic                    push_ok_s;
  logic                    drop_s;
  logic [PTR_W-1:0]        rd_next_s;

  // Accumulate, detect block end and compute all next-state values
  always_comb begin
    in_ext_s    = {{DECIM_LOG2{bus.in_data[WIDTH-1]}}, bus.in_data};
    sum_s       = acc_q + in_ext_s;
    // Floor division by N; the high bits are pure sign extension so truncation is lossless
    avg_s       = WIDTH'(sum_s >>> DECIM_LOG2);
    block_end_s = bus.in_valid && (cnt_q == CNT_LAST);
    pop_s       = (level_q != LVL_EMPTY) && bus.out_ready;
    // A same-edge pop frees a slot, so a full FIFO still accepts the push
    push_ok_s   = block_end_s && ((level_q != LVL_FULL) || pop_s);
    drop_s      = block_end_s && (level_q == LVL_FULL) && !pop_s;
    rd_next_s   = rd_ptr_q + PTR_W'(1);

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.in_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (block_end_s) begin
        acc_d = '0;
      end else begin
        acc_d = sum_s;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_ok_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_s && !push_ok_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end

    // Head register tracks the entry at the read pointer after this edge
    if (push_ok_s && ((level_q == LVL_EMPTY) || (pop_s && (level_q == LVL_ONE)))) begin
      out_data_d = avg_s;
    end else if (pop_s && (level_q > LVL_ONE)) begin
      out_data_d = mem_q[rd_next_s];
    end else begin
      out_data_d = out_data_q;
    end

    out_valid_d = (level_d != LVL_EMPTY);

    // A drop on the same edge as a clear leaves the flag set
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are only observable through the head register
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= avg_s;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_audio_boxcar_decimator.sv
// Randomised and directed bench for audio_boxcar_decimator, compared every
// cycle against a queue-based reference model of block averaging + FIFO.
module tb_audio_boxcar_decimator;

  localparam int WIDTH = 16;
  localparam int DL    = 2;
  localparam int FL    = 2;
  localparam int N     = 1 << DL;
  localparam int D     = 1 << FL;

  logic clk;
  logic reset;

  audio_boxcar_decimator_if #(.WIDTH(WIDTH), .FIFO_DEPTH_LOG2(FL)) dif ();

  audio_boxcar_decimator #(
    .WIDTH(WIDTH), .DECIM_LOG2(DL), .FIFO_DEPTH_LOG2(FL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model state
  int q[$];
  int m_acc;
  int m_cnt;
  bit m_ovf;
  int m_head;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_acc  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_head = 0;
  endfunction

  function automatic void model_edge(input bit v, input int d, input bit rdy, input bit clr);
    bit drop;
    int avg;
    drop = 1'b0;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (v) begin
      m_acc += d;
      m_cnt++;
      if (m_cnt == N) begin
        avg   = m_acc >>> DL;
        m_acc = 0;
        m_cnt = 0;
        if (q.size() < D) q.push_back(avg);
        else drop = 1'b1;
      end
    end
    if (clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    if (q.size() > 0) m_head = q[0];
  endfunction

  task automatic check_all();
    chk("out_valid",  int'(dif.out_valid), (q.size() > 0) ? 1 : 0);
    chk("fifo_level", int'(dif.fifo_level), q.size());
    chk("out_data",   int'($signed(dif.out_data)), m_head);
    chk("overflow",   int'(dif.overflow), int'(m_ovf));
  endtask

  task automatic drive(input bit v, input int d, input bit rdy, input bit clr);
    @(negedge clk);
    dif.in_valid  = v;
    dif.in_data   = d[WIDTH-1:0];
    dif.out_ready = rdy;
    dif.clear_ovf = clr;
    @(posedge clk);
    model_edge(v, d, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic feed_block(input int value, input bit rdy);
    for (int i = 0; i < N; i++) drive(1'b1, value, rdy, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.clear_ovf = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid", int'(dif.out_valid), 0);
    chk("rst_level", int'(dif.fifo_level), 0);
    chk("rst_data",  int'(dif.out_data), 0);
    chk("rst_ovf",   int'(dif.overflow), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int d;
    bit v, r, c;
    reset         = 1'b1;
    dif.in_valid  = 1'b0;
    dif.in_data   = '0;
    dif.out_ready = 1'b0;
    dif.clear_ovf = 1'b0;
    model_reset();
    #3;
    chk("init_valid", int'(dif.out_valid), 0);
    chk("init_level", int'(dif.fifo_level), 0);
    chk("init_data",  int'(dif.out_data), 0);
    chk("init_ovf",   int'(dif.overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic average 1,2,3,4 -> 2
    drive(1'b1, 1, 1'b1, 1'b0);
    drive(1'b1, 2, 1'b1, 1'b0);
    drive(1'b1, 3, 1'b1, 1'b0);
    chk("basic_early", int'(dif.out_valid), 0);
    drive(1'b1, 4, 1'b1, 1'b0);
    chk("basic_valid", int'(dif.out_valid), 1);
    chk("basic_avg",   int'($signed(dif.out_data)), 2);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("basic_popped", int'(dif.out_valid), 0);

    // Negative rounding toward -infinity
    drive(1'b1, -1, 1'b1, 1'b0);
    drive(1'b1, -1, 1'b1, 1'b0);
    drive(1'b1, -1, 1'b1, 1'b0);
    drive(1'b1, -2, 1'b1, 1'b0);
    chk("neg_round", int'(dif.out_data), 16'hFFFE);

    // Full scale
    feed_block(32767, 1'b1);
    chk("pos_full", int'($signed(dif.out_data)), 32767);
    feed_block(-32768, 1'b1);
    chk("neg_full", int'($signed(dif.out_data)), -32768);
    drive(1'b0, 0, 1'b1, 1'b0);

    // Gapped input
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 8, 1'b1, 1'b0);
      if (i < N - 1) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 0, 1'b1, 1'b0);
          chk("gap_novalid", int'(dif.out_valid), 0);
        end
      end
    end
    chk("gap_valid", int'(dif.out_valid), 1);
    chk("gap_data",  int'($signed(dif.out_data)), 8);
    drive(1'b0, 0, 1'b1, 1'b0);

    // Backpressure and overflow
    for (int b = 1; b <= 5; b++) feed_block(10 * b, 1'b0);
    chk("bp_level", int'(dif.fifo_level), 4);
    chk("bp_ovf",   int'(dif.overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", int'($signed(dif.out_data)), 10 * (i + 1));
      drive(1'b0, 0, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(dif.out_valid), 0);
    chk("ovf_sticky",  int'(dif.overflow), 1);
    drive(1'b0, 0, 1'b0, 1'b1);
    chk("ovf_cleared", int'(dif.overflow), 0);

    // Full FIFO with pop on the block-end edge
    for (int b = 1; b <= 4; b++) feed_block(b, 1'b0);
    for (int i = 0; i < N - 1; i++) drive(1'b1, 5, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b1, 1'b0);
    chk("fullpop_level", int'(dif.fifo_level), 4);
    chk("fullpop_ovf",   int'(dif.overflow), 0);
    chk("fullpop_head",  int'($signed(dif.out_data)), 2);

    // Partial block then reset mid-run with a non-empty FIFO
    drive(1'b1, 9, 1'b0, 1'b0);
    drive(1'b1, 9, 1'b0, 1'b0);
    do_reset();
    feed_block(7, 1'b0);
    chk("postrst_level", int'(dif.fifo_level), 1);
    chk("postrst_data",  int'($signed(dif.out_data)), 7);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      else d = int'($urandom_range(0, 65535)) - 32768;
      drive(v, d, r, c);
      if (k == 1500) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
